// File: rtl/clz_norm_pipe_if.sv
// rtl/clz_norm_pipe_if.sv - handshake bus for the pipelined count-leading-zeros / normalise unit
interface clz_norm_pipe_if #(
    parameter int DATA_W = 128
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_word;
    logic              o_valid;
    logic              i_ready;
    logic [CNT_W-1:0]  o_result;
    logic [DATA_W-1:0] o_norm;
    logic              o_zero;

    // Upstream/downstream side (drives the word in, consumes the result)
    modport master (
        output i_valid, i_word, i_ready,
        input  o_ready, o_valid, o_result, o_norm, o_zero
    );

    // Pipe side
    modport slave (
        input  i_valid, i_word, i_ready,
        output o_ready, o_valid, o_result, o_norm, o_zero
    );
endinterface

// File: rtl/clz_norm_pipe.sv
// rtl/clz_norm_pipe.sv - pipelined count-leading-zeros and MSB-normalise unit with full-pipe stall
module clz_norm_pipe #(
    parameter int DATA_W    = 128,
    parameter int REG_EVERY = 1
) (
    input  logic          clk,
    input  logic          reset,
    clz_norm_pipe_if.slave bus
);
    localparam int S     = $clog2(DATA_W);
    localparam int CNT_W = S + 1;

    // Output bank; always present regardless of REG_EVERY
    logic              out_vld;
    logic [CNT_W-1:0]  out_res;
    logic [DATA_W-1:0] out_norm;
    logic              out_zero;

    // Whole pipe advances together; a stalled output freezes every bank
    logic adv;
    assign adv         = ~out_vld | bus.i_ready;
    assign bus.o_ready = adv | reset;

    genvar s;
    generate
        for (s = 0; s < S; s++) begin : g_stage
            // Stage s examines the top 2^K bits, K counting down from S-1
            localparam int K  = S - 1 - s;
            localparam int SH = 1 << K;
            // Last stage feeds the output bank directly, so it is never registered here
            localparam bit REG = (s != S - 1) && (((s + 1) % REG_EVERY) == 0);

            logic [DATA_W-1:0] in_word;
            logic [DATA_W-1:0] nxt_word;
            logic [DATA_W-1:0] out_word;
            logic [CNT_W-1:0]  in_cnt;
            logic [CNT_W-1:0]  nxt_cnt;
            logic [CNT_W-1:0]  out_cnt;
            logic              in_vld;
            logic              out_vld_s;

            if (s == 0) begin : g_src
                assign in_word = bus.i_word;
                assign in_cnt  = '0;
                assign in_vld  = bus.i_valid & adv;
            end else begin : g_src
                assign in_word = g_stage[s-1].out_word;
                assign in_cnt  = g_stage[s-1].out_cnt;
                assign in_vld  = g_stage[s-1].out_vld_s;
            end

            // Halving step: an all-zero upper slice sets count bit K and shifts it out
            always_comb begin
                nxt_word = in_word;
                nxt_cnt  = in_cnt;
                if (in_word[DATA_W-1 -: SH] == '0) begin
                    nxt_word = in_word << SH;
                    nxt_cnt  = in_cnt | CNT_W'(SH);
                end
            end

            if (REG) begin : g_reg
                // Intermediate bank: valid clears on reset, data loads only on advance
                always_ff @(posedge clk) begin
                    if (reset) begin
                        out_vld_s <= 1'b0;
                        out_word  <= '0;
                        out_cnt   <= '0;
                    end else if (adv) begin
                        out_vld_s <= in_vld;
                        out_word  <= nxt_word;
                        out_cnt   <= nxt_cnt;
                    end
                end
            end else begin : g_pass
                assign out_vld_s = in_vld;
                assign out_word  = nxt_word;
                assign out_cnt   = nxt_cnt;
            end
        end
    endgenerate

    // A word still zero after every stage has collected all ones in the count; override to DATA_W
    logic [DATA_W-1:0] fin_word;
    logic [CNT_W-1:0]  fin_cnt;
    logic              fin_vld;
    logic              fin_zero;
    assign fin_word = g_stage[S-1].out_word;
    assign fin_cnt  = g_stage[S-1].out_cnt;
    assign fin_vld  = g_stage[S-1].out_vld_s;
    assign fin_zero = (fin_word == '0);

    // Output bank: held stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld  <= 1'b0;
            out_res  <= '0;
            out_norm <= '0;
            out_zero <= 1'b0;
        end else if (adv) begin
            out_vld  <= fin_vld;
            out_res  <= fin_zero ? CNT_W'(DATA_W) : fin_cnt;
            out_norm <= fin_word;
            out_zero <= fin_zero;
        end
    end

    assign bus.o_valid  = out_vld;
    assign bus.o_result = out_res;
    assign bus.o_norm   = out_norm;
    assign bus.o_zero   = out_zero;
endmodule

// File: tb/tb_clz_norm_pipe.sv
// tb/tb_clz_norm_pipe.sv - directed self-checking bench for clz_norm_pipe (128/1 and 32/2 builds)
module tb_clz_norm_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    clz_norm_pipe_if #(.DATA_W(128)) ba ();
    clz_norm_pipe_if #(.DATA_W(32))  bb ();

    clz_norm_pipe #(.DATA_W(128), .REG_EVERY(1)) u_a (.clk(clk), .reset(reset), .bus(ba.slave));
    clz_norm_pipe #(.DATA_W(32),  .REG_EVERY(2)) u_b (.clk(clk), .reset(reset), .bus(bb.slave));

    int n_vec = 0;
    int n_bad = 0;
    int n_cons_a = 0;
    int n_cons_b = 0;

    int           qa_res[$];
    logic [127:0] qa_norm[$];
    logic         qa_zero[$];
    int           qb_res[$];
    logic [127:0] qb_norm[$];
    logic         qb_zero[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Linear MSB scan, independent of the halving structure
    function automatic void ref_clz(input logic [127:0] w, input int width,
                                    output int cnt, output logic [127:0] nrm);
        bit found = 0;
        cnt = width;
        for (int i = width - 1; i >= 0; i--) begin
            if (!found && w[i]) begin
                cnt   = width - 1 - i;
                found = 1;
            end
        end
        nrm = (cnt == width) ? 128'd0 : (w << cnt);
    endfunction

    // One clock: score consumed outputs, record accepted inputs, then advance
    task automatic tick();
        int           c;
        logic [127:0] nm;
        #1;
        if (reset) begin
            qa_res.delete(); qa_norm.delete(); qa_zero.delete();
            qb_res.delete(); qb_norm.delete(); qb_zero.delete();
        end else begin
            if (ba.o_valid && ba.i_ready) begin
                n_vec++;
                assert (qa_res.size() != 0) else begin
                    n_bad++;
                    $error("FAIL a_extra: got output result=%0d, want no output", ba.o_result);
                end
                if (qa_res.size() != 0) begin
                    chk("a_sb_res",  128'(ba.o_result), 128'(qa_res.pop_front()));
                    chk("a_sb_norm", ba.o_norm, qa_norm.pop_front());
                    chk("a_sb_zero", 128'(ba.o_zero), 128'(qa_zero.pop_front()));
                end
                n_cons_a++;
            end
            if (bb.o_valid && bb.i_ready) begin
                n_vec++;
                assert (qb_res.size() != 0) else begin
                    n_bad++;
                    $error("FAIL b_extra: got output result=%0d, want no output", bb.o_result);
                end
                if (qb_res.size() != 0) begin
                    chk("b_sb_res",  128'(bb.o_result), 128'(qb_res.pop_front()));
                    chk("b_sb_norm", 128'(bb.o_norm), qb_norm.pop_front());
                    chk("b_sb_zero", 128'(bb.o_zero), 128'(qb_zero.pop_front()));
                end
                n_cons_b++;
            end
            if (ba.i_valid && ba.o_ready) begin
                ref_clz(ba.i_word, 128, c, nm);
                qa_res.push_back(c); qa_norm.push_back(nm); qa_zero.push_back(c == 128);
            end
            if (bb.i_valid && bb.o_ready) begin
                ref_clz(128'(bb.i_word), 32, c, nm);
                qb_res.push_back(c); qb_norm.push_back(nm); qb_zero.push_back(c == 32);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w = 0;
        while ((qa_res.size() != 0 || qb_res.size() != 0) && w < 300) begin
            tick();
            w++;
        end
        chk("drain_left", 128'(qa_res.size() + qb_res.size()), 128'(0));
    endtask

    task automatic wait_a_valid(input string tag);
        int w = 0;
        while (!ba.o_valid && w < 20) begin
            tick();
            w++;
        end
        chk(tag, 128'(ba.o_valid), 128'(1));
    endtask

    initial begin
        int           vcnt;
        int           cons0;
        logic [127:0] one;
        one = 128'd1;

        reset = 1'b1;
        ba.i_valid = 1'b0; ba.i_word = '0; ba.i_ready = 1'b1;
        bb.i_valid = 1'b0; bb.i_word = '0; bb.i_ready = 1'b1;
        #1;
        chk("rst_oready_a", 128'(ba.o_ready), 128'(1));
        tick();
        ba.i_valid = 1'b1; ba.i_word = one;
        tick();
        chk("rst_oready_held", 128'(ba.o_ready), 128'(1));
        ba.i_valid = 1'b0;
        reset = 1'b0;
        chk("rst_ovalid", 128'(ba.o_valid), 128'(0));
        chk("rst_result", 128'(ba.o_result), 128'(0));
        chk("rst_norm",   ba.o_norm, 128'(0));
        chk("rst_zero",   128'(ba.o_zero), 128'(0));
        chk("rst_ovalid_b", 128'(bb.o_valid), 128'(0));

        // 1: single word, exact latency of 7
        ba.i_valid = 1'b1; ba.i_word = one;
        tick();
        ba.i_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("t1_lat_early", 128'(ba.o_valid), 128'(0));
            tick();
        end
        chk("t1_valid", 128'(ba.o_valid), 128'(1));
        chk("t1_result", 128'(ba.o_result), 128'(127));
        chk("t1_norm", ba.o_norm, one << 127);
        chk("t1_zero", 128'(ba.o_zero), 128'(0));
        tick();

        // 2: all-zero then MSB-only
        ba.i_valid = 1'b1; ba.i_word = '0;
        tick();
        ba.i_word = one << 127;
        tick();
        ba.i_valid = 1'b0;
        wait_a_valid("t2_timeout");
        chk("t2_zero_res",  128'(ba.o_result), 128'(128));
        chk("t2_zero_norm", ba.o_norm, 128'(0));
        chk("t2_zero_flag", 128'(ba.o_zero), 128'(1));
        tick();
        chk("t2_msb_valid", 128'(ba.o_valid), 128'(1));
        chk("t2_msb_res",   128'(ba.o_result), 128'(0));
        chk("t2_msb_norm",  ba.o_norm, one << 127);
        chk("t2_msb_zero",  128'(ba.o_zero), 128'(0));
        tick();
        drain();

        // 3: back-to-back 1<<n stream, 128 contiguous valid cycles
        vcnt = 0;
        for (int n = 0; n < 128; n++) begin
            ba.i_valid = 1'b1; ba.i_word = one << n;
            if (ba.o_valid) vcnt++;
            tick();
        end
        ba.i_valid = 1'b0;
        for (int w = 0; w < 20 && ba.o_valid; w++) begin
            vcnt++;
            tick();
        end
        chk("t3_valid_run", 128'(vcnt), 128'(128));
        chk("t3_left", 128'(qa_res.size()), 128'(0));

        // 4: 5-cycle downstream stall mid-stream
        cons0 = n_cons_a;
        for (int n = 0; n < 40; n++) begin
            ba.i_valid = 1'b1; ba.i_word = (128'(n) + 128'd1) << (2 * n);
            if (n == 20) begin
                ba.i_ready = 1'b0;
                #1;
                for (int k = 0; k < 5; k++) begin
                    chk("t4_oready", 128'(ba.o_ready), 128'(0));
                    chk("t4_hold_valid", 128'(ba.o_valid), 128'(1));
                    chk("t4_hold_res", 128'(ba.o_result), 128'(qa_res[0]));
                    chk("t4_hold_norm", ba.o_norm, qa_norm[0]);
                    tick();
                end
                ba.i_ready = 1'b1;
            end
            tick();
        end
        ba.i_valid = 1'b0;
        drain();
        chk("t4_count", 128'(n_cons_a - cons0), 128'(40));

        // 5: reset with 4 words in flight
        for (int n = 0; n < 4; n++) begin
            ba.i_valid = 1'b1; ba.i_word = one << (10 * n);
            tick();
        end
        ba.i_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid_after_rst", 128'(ba.o_valid), 128'(0));
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t5_no_ghost", 128'(ba.o_valid), 128'(0));
        end
        ba.i_valid = 1'b1; ba.i_word = 128'h80;
        tick();
        ba.i_valid = 1'b0;
        wait_a_valid("t5_timeout");
        chk("t5_new_res", 128'(ba.o_result), 128'(120));
        chk("t5_new_norm", ba.o_norm, one << 127);
        tick();

        // 6: DATA_W=32, REG_EVERY=2 build
        bb.i_valid = 1'b1; bb.i_word = 32'h0000FFFF;
        tick();
        bb.i_valid = 1'b0;
        chk("t6_lat1", 128'(bb.o_valid), 128'(0));
        tick();
        chk("t6_lat2", 128'(bb.o_valid), 128'(0));
        tick();
        chk("t6_valid", 128'(bb.o_valid), 128'(1));
        chk("t6_res", 128'(bb.o_result), 128'(16));
        chk("t6_norm", 128'(bb.o_norm), 128'hFFFF0000);
        chk("t6_zero", 128'(bb.o_zero), 128'(0));
        tick();
        cons0 = n_cons_b;
        bb.i_valid = 1'b1; bb.i_word = 32'h0;
        tick();
        bb.i_word = 32'hFFFFFFFF;
        tick();
        bb.i_word = 32'h1;
        tick();
        for (int i = 0; i < 60; i++) begin
            bb.i_valid = ($urandom_range(0, 3) != 0);
            bb.i_word  = $urandom >> $urandom_range(0, 31);
            bb.i_ready = ($urandom_range(0, 4) != 0);
            tick();
        end
        bb.i_valid = 1'b0;
        bb.i_ready = 1'b1;
        drain();
        chk("t6_seen_some", 128'(n_cons_b - cons0 > 20), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
